// File: rtl/serv_immenc.sv
// serv_immenc: bit-serial immediate encoder. Collects a 32-bit immediate
// LSB-first and packs it with parallel register/opcode fields into an RV32
// instruction word (R/I/S/B/U/J). It also flags immediates that the chosen
// format cannot represent.
module serv_immenc (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_fmt,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic        i_imm,
  input  logic        i_imm_valid,
  output logic        o_busy,
  output logic [31:0] o_insn,
  output logic        o_err,
  output logic        o_valid,
  input  logic        i_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [1:0]  state;
  logic [2:0]  fmt_q, f3_q;
  logic [6:0]  op_q, f7_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [4:0]  cnt;
  logic [31:0] imm_q;

  // Packing sources: the live inputs while idle (R/illegal pack on the start
  // cycle), the latched fields otherwise. The immediate includes the bit
  // arriving this cycle, so the result can be registered on the last strobe.
  logic        idle;
  logic [2:0]  s_fmt, s_f3;
  logic [6:0]  s_op, s_f7;
  logic [4:0]  s_rd, s_rs1, s_rs2;
  logic [31:0] s_imm;
  logic        fmt_serial;

  // Select the packing source between the live inputs and the latched fields.
  always_comb begin
    idle       = (state == IDLE);
    s_fmt      = idle ? i_fmt    : fmt_q;
    s_op       = idle ? i_opcode : op_q;
    s_f3       = idle ? i_funct3 : f3_q;
    s_f7       = idle ? i_funct7 : f7_q;
    s_rd       = idle ? i_rd     : rd_q;
    s_rs1      = idle ? i_rs1    : rs1_q;
    s_rs2      = idle ? i_rs2    : rs2_q;
    s_imm      = {i_imm, imm_q[31:1]};
    fmt_serial = (i_fmt != FMT_R) && (i_fmt <= FMT_J);
  end

  logic [31:0] pk_insn;
  logic        pk_err;

  // Pack the word for the selected format and check that the immediate fits.
  // A "fits" check means that the bits above the encoded field are a pure
  // sign extension, and that the bits below it are zero where the format drops them.
  always_comb begin
    pk_insn = {s_f7, s_rs2, s_rs1, s_f3, s_rd, s_op};
    pk_err  = 1'b0;
    case (s_fmt)
      FMT_R: pk_err = 1'b0;
      FMT_I: begin
        pk_insn = {s_imm[11:0], s_rs1, s_f3, s_rd, s_op};
        pk_err  = !((&s_imm[31:11]) || !(|s_imm[31:11]));
      end
      FMT_S: begin
        pk_insn = {s_imm[11:5], s_rs2, s_rs1, s_f3, s_imm[4:0], s_op};
        pk_err  = !((&s_imm[31:11]) || !(|s_imm[31:11]));
      end
      FMT_B: begin
        pk_insn = {s_imm[12], s_imm[10:5], s_rs2, s_rs1, s_f3,
                   s_imm[4:1], s_imm[11], s_op};
        pk_err  = s_imm[0] || !((&s_imm[31:12]) || !(|s_imm[31:12]));
      end
      FMT_U: begin
        pk_insn = {s_imm[31:12], s_rd, s_op};
        pk_err  = |s_imm[11:0];
      end
      FMT_J: begin
        pk_insn = {s_imm[20], s_imm[10:1], s_imm[11], s_imm[19:12], s_rd, s_op};
        pk_err  = s_imm[0] || !((&s_imm[31:20]) || !(|s_imm[31:20]));
      end
      default: pk_err = 1'b1;
    endcase
  end

  // Control FSM: latch on start, shift 32 bits, then hold the result until it is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      fmt_q   <= '0;
      op_q    <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      cnt     <= '0;
      imm_q   <= '0;
      o_insn  <= '0;
      o_err   <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          fmt_q <= i_fmt;
          op_q  <= i_opcode;
          f3_q  <= i_funct3;
          f7_q  <= i_funct7;
          rd_q  <= i_rd;
          rs1_q <= i_rs1;
          rs2_q <= i_rs2;
          cnt   <= '0;
          imm_q <= '0;
          if (fmt_serial) begin
            state <= SHIFT;
          end else begin
            o_insn  <= pk_insn;
            o_err   <= pk_err;
            o_valid <= 1'b1;
            state   <= DONE;
          end
        end
        SHIFT: if (i_imm_valid) begin
          imm_q <= s_imm;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            o_insn  <= pk_insn;
            o_err   <= pk_err;
            o_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: if (i_ready) begin
          o_valid <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_serv_immenc.sv
// Directed bench for serv_immenc: hand-computed encodings, error flags,
// latency, stalls, backpressure, ignored starts and a mid-shift reset.
module tb_serv_immenc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  fmt = '0;
  logic [6:0]  op = '0;
  logic [2:0]  f3 = '0;
  logic [6:0]  f7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic        imm = 1'b0;
  logic        imm_valid = 1'b0;
  logic        ready = 1'b0;
  logic        busy, err, valid;
  logic [31:0] insn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serv_immenc dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_fmt(fmt),
    .i_opcode(op), .i_funct3(f3), .i_funct7(f7), .i_rd(rd), .i_rs1(rs1),
    .i_rs2(rs2), .i_imm(imm), .i_imm_valid(imm_valid), .o_busy(busy),
    .o_insn(insn), .o_err(err), .o_valid(valid), .i_ready(ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Start an encode, then shift nbits bits of v with 'gap' idle cycles after each
  // strobe. With poke set, an ignored fmt=7 start is pulsed during bit 5.
  // For a full encode, check latency, the word and the error flag.
  task automatic encode(input string tag, input logic [2:0] f, input logic [6:0] o,
                        input logic [2:0] fn3, input logic [6:0] fn7,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] v, input int gap, input int nbits,
                        input bit poke, input logic [31:0] exp_insn, input logic exp_err);
    @(negedge clk);
    start = 1'b1; fmt = f; op = o; f3 = fn3; f7 = fn7; rd = d; rs1 = s1; rs2 = s2;
    @(negedge clk);
    start = 1'b0;
    if (f >= 3'd1 && f <= 3'd5) begin
      for (int i = 0; i < nbits; i++) begin
        if (i == 31) chk({tag, "_pre_valid"}, {31'd0, valid}, 32'd0);
        imm = v[i]; imm_valid = 1'b1;
        if (poke && i == 5) begin
          start = 1'b1; fmt = 3'd7; op = 7'h7F; rd = 5'd31;
        end
        @(negedge clk);
        imm_valid = 1'b0; start = 1'b0;
        if (i == 31) chk({tag, "_lat"}, {31'd0, valid}, 32'd1);
        else repeat (gap) @(negedge clk);
      end
    end else begin
      chk({tag, "_lat"}, {31'd0, valid}, 32'd1);
    end
    if (nbits == 32) begin
      chk({tag, "_insn"}, insn, exp_insn);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    end
  endtask

  // Accept the result, optionally with a simultaneous start that must be ignored.
  task automatic accept(input string tag, input bit with_start);
    ready = 1'b1;
    if (with_start) begin start = 1'b1; fmt = 3'd1; end
    @(negedge clk);
    ready = 1'b0; start = 1'b0;
    chk({tag, "_acc_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_acc_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    #2;
    chk("rst_insn", insn, 32'd0);
    chk("rst_flags", {28'd0, busy, valid, err, 1'b0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // I-type, all-ones immediate (-1)
    encode("i_m1", 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 0, 32, 0,
           32'hFFF00093, 1'b0);
    accept("i_m1", 0);
    // B-type, offset 8
    encode("b_8", 3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 0, 32, 0,
           32'h00208463, 1'b0);
    accept("b_8", 0);
    // U-type
    encode("u", 3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 0, 32, 0,
           32'h123452B7, 1'b0);
    accept("u", 0);
    // S-type sw x3,-4(x2)
    encode("s_m4", 3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd3, 32'hFFFFFFFC, 0, 32, 0,
           32'hFE312E23, 1'b0);
    accept("s_m4", 0);
    // J-type out of range: bit 20 set, no sign extension
    encode("j_rng", 3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00100000, 0, 32, 0,
           32'h800000EF, 1'b1);
    accept("j_rng", 0);
    // B-type odd offset
    encode("b_odd", 3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7, 0, 32, 0,
           32'h00208363, 1'b1);
    accept("b_odd", 0);
    // I-type 0x800 is not sign-representable in 12 bits
    encode("i_800", 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 0, 32, 0,
           32'h80000093, 1'b1);
    accept("i_800", 0);
    // R-type and illegal fmt: no bits consumed, valid on the next cycle
    encode("r", 3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0, 0, 32, 0,
           32'h403100B3, 1'b0);
    accept("r", 0);
    encode("f7", 3'd7, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0, 0, 32, 0,
           32'h403100B3, 1'b1);
    accept("f7", 0);

    // Stalled strobes with a stray start mid-shift; same result as back-to-back
    encode("s_gap", 3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd3, 32'hFFFFFFFC, 3, 32, 1,
           32'hFE312E23, 1'b0);
    // Backpressure: the result is held for 10 cycles, with a start that is ignored
    held = insn;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin start = 1'b1; fmt = 3'd0; op = 7'h01; end
      @(negedge clk);
      start = 1'b0;
      chk("hold", {valid, insn[30:0]}, {1'b1, held[30:0]});
      chk("hold_msb", {31'd0, insn[31]}, {31'd0, held[31]});
    end
    accept("s_gap", 1);

    // Reset after 10 bits: outputs clear at once; the next encode is clean
    encode("rst_mid", 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 0, 10, 0,
           32'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_insn", insn, 32'd0);
    chk("mid_rst_flags", {29'd0, busy, valid, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    encode("i_post", 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 0, 32, 0,
           32'hFFF00093, 1'b0);
    accept("i_post", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
